// File: rtl/telemetry_pkg.sv
// Shared defaults, sweep-state encoding and coordinate field layout for the track file.
package telemetry_pkg;
  localparam int NUM_TARGETS_DEF = 16;
  localparam int COORD_W_DEF     = 8;
  localparam int AGE_W_DEF       = 4;
  localparam int MAX_AGE_DEF     = 15;

  // Field slots inside a packed {X,Y,Z,T} word, X in the MSBs.
  localparam int FLD_X = 3;
  localparam int FLD_Y = 2;
  localparam int FLD_Z = 1;
  localparam int FLD_T = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_PRESENT,
    S_DONE
  } sweep_state_t;

  // LSB position of a coordinate field for a given field width.
  function automatic int fld_lsb(input int fld, input int coord_w);
    return fld * coord_w;
  endfunction
endpackage

// File: rtl/track_entry.sv
// One track slot: coordinate word, valid flag and a saturating age counter.
module track_entry
  import telemetry_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int AGE_W   = AGE_W_DEF,
  parameter int MAX_AGE = MAX_AGE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               clr,
  input  logic               tick,
  input  logic [4*COORD_W-1:0] wr_coord,
  output logic [4*COORD_W-1:0] coord,
  output logic               valid,
  output logic               stale
);
  localparam logic [AGE_W-1:0] AGE_SAT = '1;

  logic [AGE_W-1:0] age;

  // Write beats clear; age restarts on write, is pinned at zero while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coord <= '0;
      valid <= 1'b0;
      age   <= '0;
    end else if (wr) begin
      coord <= wr_coord;
      valid <= 1'b1;
      age   <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (tick && valid && (age != AGE_SAT)) begin
      age <= age + 1'b1;
    end
  end

  assign stale = valid && (age >= AGE_W'(MAX_AGE));
endmodule

// File: rtl/target_track_file.sv
// Target track file: per-target entries, registered random read, live population
// count and a handshaked sweep that presents every valid entry in index order.
module target_track_file
  import telemetry_pkg::*;
#(
  parameter  int NUM_TARGETS = NUM_TARGETS_DEF,
  parameter  int COORD_W     = COORD_W_DEF,
  parameter  int AGE_W       = AGE_W_DEF,
  parameter  int MAX_AGE     = MAX_AGE_DEF,
  localparam int IDX_W       = $clog2(NUM_TARGETS),
  localparam int CW          = 4 * COORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CW-1:0]    wr_coord,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             age_tick,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CW-1:0]    rd_coord,
  output logic             rd_valid,
  output logic             rd_stale,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CW-1:0]    out_coord,
  output logic             out_stale,
  output logic             scan_done,
  output logic [IDX_W:0]   valid_count
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TARGETS - 1);

  logic [NUM_TARGETS-1:0][CW-1:0] coord_q;
  logic [NUM_TARGETS-1:0]         valid_q;
  logic [NUM_TARGETS-1:0]         stale_q;

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_entry
    track_entry #(
      .COORD_W (COORD_W),
      .AGE_W   (AGE_W),
      .MAX_AGE (MAX_AGE)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_en  && (wr_idx  == IDX_W'(g))),
      .clr      (clr_en && (clr_idx == IDX_W'(g))),
      .tick     (age_tick),
      .wr_coord (wr_coord),
      .coord    (coord_q[g]),
      .valid    (valid_q[g]),
      .stale    (stale_q[g])
    );
  end

  logic           rd_in;
  logic [IDX_W:0] pop;

  assign rd_in = {1'b0, rd_idx} < (IDX_W+1)'(NUM_TARGETS);

  // Population count of the current valid bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_TARGETS; i++) pop = pop + (IDX_W+1)'(valid_q[i]);
  end

  // Registered random read of pre-edge storage, zeros when out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_coord    <= '0;
      rd_valid    <= 1'b0;
      rd_stale    <= 1'b0;
      valid_count <= '0;
    end else begin
      rd_coord    <= rd_in ? coord_q[rd_idx] : '0;
      rd_valid    <= rd_in && valid_q[rd_idx];
      rd_stale    <= rd_in && stale_q[rd_idx];
      valid_count <= pop;
    end
  end

  sweep_state_t     state;
  logic [IDX_W-1:0] ptr;

  assign scan_busy = (state != S_IDLE);

  // Sweep FSM: one index per cycle in SEEK, payload frozen while presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_coord <= '0;
      out_stale <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          scan_done <= 1'b0;
          if (scan_start) begin
            state <= S_SEEK;
            ptr   <= '0;
          end
        end
        S_SEEK: begin
          if (valid_q[ptr]) begin
            state     <= S_PRESENT;
            out_valid <= 1'b1;
            out_idx   <= ptr;
            out_coord <= coord_q[ptr];
            out_stale <= stale_q[ptr];
          end else if (ptr == LAST) begin
            state     <= S_DONE;
            scan_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr == LAST) begin
              state     <= S_DONE;
              scan_done <= 1'b1;
            end else begin
              state <= S_SEEK;
              ptr   <= ptr + 1'b1;
            end
          end
        end
        S_DONE: begin
          scan_done <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_target_track_file.sv
// Bench for target_track_file: vector table for write/clear/read, scoreboard for sweeps.
module tb_target_track_file;
  import telemetry_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, clr_en = 1'b0, age_tick = 1'b0;
  logic [IW-1:0] wr_idx = '0, clr_idx = '0, rd_idx = '0;
  logic [CW-1:0] wr_coord = '0;
  logic [CW-1:0] rd_coord, out_coord;
  logic          rd_valid, rd_stale, scan_start = 1'b0, scan_busy;
  logic          out_valid, out_ready = 1'b0, out_stale, scan_done;
  logic [IW-1:0] out_idx;
  logic [IW:0]   valid_count;

  target_track_file dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_coord(wr_coord),
    .clr_en(clr_en), .clr_idx(clr_idx), .age_tick(age_tick), .rd_idx(rd_idx),
    .rd_coord(rd_coord), .rd_valid(rd_valid), .rd_stale(rd_stale),
    .scan_start(scan_start), .scan_busy(scan_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_coord(out_coord),
    .out_stale(out_stale), .scan_done(scan_done), .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input int x, input int y, input int z, input int t);
    logic [CW-1:0] c;
    c = '0;
    c[fld_lsb(FLD_X, 8) +: 8] = 8'(x);
    c[fld_lsb(FLD_Y, 8) +: 8] = 8'(y);
    c[fld_lsb(FLD_Z, 8) +: 8] = 8'(z);
    c[fld_lsb(FLD_T, 8) +: 8] = 8'(t);
    return c;
  endfunction

  typedef struct {
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_coord;
    logic          clr_en;
    logic [IW-1:0] clr_idx;
    logic [IW-1:0] rd_idx;
    logic [CW-1:0] e_coord;
    logic          e_valid;
    logic [IW:0]   e_cnt;
  } vec_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [CW-1:0] coord;
    logic          stale;
  } beat_t;

  vec_t  vecs[8];
  beat_t sb[$];

  initial begin
    logic [CW-1:0] ca, cb, cb2, cc, cd, ce;
    beat_t         b;
    logic [IW-1:0] hold_idx;
    logic [CW-1:0] hold_coord;
    int            n, dones, outs;
    bit            seen;

    ca = mk(10, 20, 30, 40); cb = mk(1, 2, 3, 4); cb2 = mk(5, 6, 7, 8);
    cc = mk(8'hf0, 8'h0f, 8'haa, 8'h55); cd = mk(9, 9, 9, 9); ce = mk(77, 66, 55, 44);

    // Reset state
    repeat (2) step();
    chk("rst_rd_coord", 64'(rd_coord), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_count", 64'(valid_count), 0);
    chk("rst_busy", 64'(scan_busy), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_done", 64'(scan_done), 0);
    rst = 1'b0;
    step();

    //            wr  widx coord clr cidx ridx e_coord e_valid e_cnt
    vecs[0] = '{1'b1, 4'd3,  ca, 1'b0, 4'd0, 4'd3,  ca, 1'b1, 5'd1};
    vecs[1] = '{1'b1, 4'd2,  ce, 1'b1, 4'd2, 4'd2,  ce, 1'b1, 5'd2};
    vecs[2] = '{1'b0, 4'd0, '0,  1'b1, 4'd2, 4'd2,  ce, 1'b0, 5'd1};
    vecs[3] = '{1'b0, 4'd0, '0,  1'b1, 4'd9, 4'd3,  ca, 1'b1, 5'd1};
    vecs[4] = '{1'b1, 4'd7,  cb, 1'b0, 4'd0, 4'd7,  cb, 1'b1, 5'd2};
    vecs[5] = '{1'b1, 4'd15, cc, 1'b0, 4'd0, 4'd0, '0,  1'b0, 5'd3};
    vecs[6] = '{1'b1, 4'd0,  cd, 1'b0, 4'd0, 4'd0,  cd, 1'b1, 5'd4};
    vecs[7] = '{1'b0, 4'd0, '0,  1'b1, 4'd3, 4'd3,  ca, 1'b0, 5'd3};

    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx; wr_coord = vecs[i].wr_coord;
      clr_en = vecs[i].clr_en; clr_idx = vecs[i].clr_idx; rd_idx = vecs[i].rd_idx;
      step();
      wr_en = 1'b0; clr_en = 1'b0;
      step();
      chk($sformatf("v%0d_rd_coord", i), 64'(rd_coord), 64'(vecs[i].e_coord));
      chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_rd_stale", i), 64'(rd_stale), 0);
      chk($sformatf("v%0d_count", i), 64'(valid_count), 64'(vecs[i].e_cnt));
    end

    // Read returns storage from before a same-edge write
    rd_idx = 4'd7; wr_en = 1'b1; wr_idx = 4'd7; wr_coord = cb2;
    step();
    wr_en = 1'b0;
    chk("rbw_old", 64'(rd_coord), 64'(cb));
    step();
    chk("rbw_new", 64'(rd_coord), 64'(cb2));

    // Sweep over entries 0, 7, 15 with a 3-cycle stall on the first beat
    sb.push_back('{4'd0, cd, 1'b0});
    sb.push_back('{4'd7, cb2, 1'b0});
    sb.push_back('{4'd15, cc, 1'b0});
    out_ready = 1'b0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (out_valid) seen = 1; else step();
    end
    chk("sweep_first_beat_seen", 64'(seen), 1);
    hold_idx = out_idx; hold_coord = out_coord;
    chk("stall_idx0", 64'(hold_idx), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_valid", k), 64'(out_valid), 1);
      chk($sformatf("stall%0d_idx", k), 64'(out_idx), 64'(hold_idx));
      chk($sformatf("stall%0d_coord", k), 64'(out_coord), 64'(hold_coord));
    end
    out_ready = 1'b1;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sweep_extra_beat", 64'(out_idx), 64'hffff);
        end else begin
          b = sb.pop_front();
          chk("sweep_idx", 64'(out_idx), 64'(b.idx));
          chk("sweep_coord", 64'(out_coord), 64'(b.coord));
          chk("sweep_stale", 64'(out_stale), 64'(b.stale));
        end
      end
      if (scan_done) dones++;
      step();
    end
    chk("sweep_beats_left", 64'(sb.size()), 0);
    chk("sweep_done_pulses", 64'(dones), 1);
    chk("sweep_idle", 64'(scan_busy), 0);
    out_ready = 1'b0;

    // Aging on entry 5 up to and past staleness
    wr_en = 1'b1; wr_idx = 4'd5; wr_coord = ca; rd_idx = 4'd5;
    step();
    wr_en = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      age_tick = 1'b1;
      step();
      age_tick = 1'b0;
      step();
      chk($sformatf("age%0d_stale", t), 64'(rd_stale), 64'(t >= 15));
    end
    chk("age_valid", 64'(rd_valid), 1);
    wr_en = 1'b1; wr_idx = 4'd5; wr_coord = ce;
    step();
    wr_en = 1'b0;
    step();
    chk("rewrite_fresh", 64'(rd_stale), 0);
    chk("rewrite_coord", 64'(rd_coord), 64'(ce));

    // Empty the file
    clr_en = 1'b1;
    clr_idx = 4'd0;  step();
    clr_idx = 4'd5;  step();
    clr_idx = 4'd7;  step();
    clr_idx = 4'd15; step();
    clr_en = 1'b0;
    step();
    chk("empty_count", 64'(valid_count), 0);

    // Empty sweep: scan_done NUM_TARGETS+1 cycles after scan_start
    scan_start = 1'b1;
    n = 0; outs = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      scan_start = 1'b0;
      n++;
      if (out_valid) outs++;
      if (scan_done) seen = 1;
    end
    chk("empty_done_seen", 64'(seen), 1);
    chk("empty_done_latency", 64'(n), 64'(N + 1));
    chk("empty_no_out", 64'(outs), 0);
    step();
    chk("empty_done_single", 64'(scan_done), 0);

    // Reset mid-sweep aborts silently
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    repeat (4) step();
    chk("mid_busy", 64'(scan_busy), 1);
    rst = 1'b1;
    step();
    chk("abort_busy", 64'(scan_busy), 0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (scan_done) dones++;
    end
    chk("abort_no_done", 64'(dones), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
